// File: rtl/minimips_pkg.sv
// Shared trace-entry layout for the minimips retirement trace path.
// An entry is {seq, instr, result} with result at bit 0.
package minimips_pkg;

  localparam int RESULT_W   = 32;
  localparam int INSTR_W    = 16;
  localparam int PAYLOAD_W  = INSTR_W + RESULT_W;

  localparam int RESULT_LSB = 0;
  localparam int INSTR_LSB  = RESULT_LSB + RESULT_W;
  localparam int SEQ_LSB    = INSTR_LSB + INSTR_W;

  // The sequence field is sized by the instantiating block, so the entry width is derived.
  function automatic int entryWidth(input int seqW);
    return seqW + PAYLOAD_W;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: storage, wrapping pointers and occupancy.
// A write at full is accepted only when a read retires the head on the same edge.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wrEn,
  input  logic [WIDTH-1:0]           wrData,
  output logic                       wrAccept,
  input  logic                       rdEn,
  output logic [WIDTH-1:0]           rdData,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;
  logic             empty;
  logic             full;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign doPop    = rdEn && !empty;
  assign doPush   = wrEn && (!full || doPop);
  assign wrAccept = doPush;
  assign rdData   = mem[rdPtr];

  // NOTE: storage has no reset; only pointers and count define which words are valid.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  // NOTE: non-blocking assignments keep every register reading pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      // DEPTH is a power of two, so natural AW-bit overflow is the modulo wrap.
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_trace_buffer.sv
// Retirement trace buffer: tags each retired instruction with a sequence number,
// queues it for a consumer, and counts retirements dropped while the queue is full.
module result_trace_buffer
  import minimips_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [15:0]              in_instr,
  input  logic [31:0]              in_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [15:0]              out_instr,
  output logic [31:0]              out_result,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  input  logic                     clr_ovf
);

  localparam int EW = entryWidth(SEQ_W);

  logic [SEQ_W-1:0] seqCnt;
  logic [EW-1:0]    wrEntry;
  logic [EW-1:0]    headEntry;
  logic             wrAccept;
  logic             drop;

  assign wrEntry = {seqCnt, in_instr, in_result};

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wrEn     (in_valid),
    .wrData   (wrEntry),
    .wrAccept (wrAccept),
    .rdEn     (out_ready),
    .rdData   (headEntry),
    .count    (count)
  );

  assign out_valid  = (count != '0);
  assign out_seq    = headEntry[SEQ_LSB +: SEQ_W];
  assign out_instr  = headEntry[INSTR_LSB +: INSTR_W];
  assign out_result = headEntry[RESULT_LSB +: RESULT_W];

  assign drop = in_valid && !wrAccept;

  // The sequence advances on dropped retirements too, so gaps in out_seq expose drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seqCnt   <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (in_valid) seqCnt <= seqCnt + SEQ_W'(1);
      if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/result_trace_buffer.md
RESULT_TRACE_BUFFER -- requirements
Module: result_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, 8, FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter SEQ_W, 16, sequence-number width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  processor retired one instruction this cycle.
REQ-006 SHALL have port in_instr  input  16  retired instruction word (processor finstruction).
REQ-007 SHALL have port in_result  input  32  register write-back value (processor result).
REQ-008 SHALL have port out_valid  output  1  head entry available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-010 SHALL have port out_seq  output  SEQ_W  sequence number of head entry.
REQ-011 SHALL have port out_instr  output  16  instruction of head entry.
REQ-012 SHALL have port out_result  output  32  result of head entry.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port overflow  output  1  sticky: at least one retirement dropped.
REQ-015 SHALL have port drop_cnt  output  8  dropped retirements, saturating.
REQ-016 SHALL have port clr_ovf  input  1  synchronous clear of overflow and drop_cnt.

Function
REQ-017 SHALL, on each rising edge with in_valid=1 and a slot free, write {seq, in_instr, in_result} at the tail.
REQ-018 SHALL treat a slot as free when count<DEPTH, or when count==DEPTH and out_valid&out_ready in the same cycle (simultaneous push/pop at full is accepted).
REQ-019 SHALL increment the internal sequence counter on every in_valid=1 cycle, accepted or dropped, wrapping from 2^SEQ_W-1 to 0; gaps in out_seq mark drops.
REQ-020 SHALL, on in_valid=1 with no free slot, discard the entry, set overflow, and increment drop_cnt saturating at 0xFF.
REQ-021 SHALL give clr_ovf priority over a same-cycle drop: overflow=0, drop_cnt=0 after that edge.
REQ-022 SHALL be first-word-fall-through: out_valid=(count!=0); out_seq/out_instr/out_result reflect the head combinationally from storage.
REQ-023 SHALL have one-cycle write latency: an entry accepted at edge N is visible on out_* after edge N when the FIFO was empty.
REQ-024 SHALL pop the head on an edge where out_valid&out_ready=1; out_ready while empty SHALL have no effect.
REQ-025 SHALL keep count unchanged on simultaneous accepted push and pop, +1 on push only, -1 on pop only.
REQ-026 SHALL wrap read and write pointers modulo DEPTH.
REQ-027 SHALL keep out_* data don't-care when out_valid=0; the bench SHALL NOT check it.
REQ-028 SHALL preserve entry order exactly (no reordering, no duplication).

Reset
REQ-029 SHALL, while rst_n=0, force pointers=0, count=0, out_valid=0, seq counter=0, overflow=0, drop_cnt=0.
REQ-030 SHALL discard all buffered entries on reset mid-operation; storage contents need no reset.
REQ-031 SHALL ignore in_valid and out_ready on the first edge after rst_n deasserts only if it lies within the same cycle as deassertion; thereafter normal operation.

Structure
REQ-032 SHALL place the trace entry width constant (SEQ_W+48) and field offsets in shared package minimips_pkg.
REQ-033 SHALL implement storage and pointers in one sub-module, sync_fifo, with the drop/sequence/status logic in the top.

Verification
REQ-034 SHALL cover single retire: in_valid 1 cycle, instr=0x1234, result=0x0000_00AB, out_ready=1 -> next cycle out_valid=1, seq=0, instr=0x1234, result=0xAB; popped; count returns 0.
REQ-035 SHALL cover fill and overflow: DEPTH=8, out_ready=0, 10 retires -> count=8, overflow=1, drop_cnt=2; drain yields seq 0..7 in order.
REQ-036 SHALL cover full with simultaneous push/pop: count=8, in_valid=1, out_ready=1 -> count stays 8, no drop, new entry becomes tail.
REQ-037 SHALL cover sequence wrap: SEQ_W=4, 18 retires with out_ready=1 -> out_seq runs 0..15,0,1.
REQ-038 SHALL cover reset mid-operation: count=5, rst_n low 1 cycle -> out_valid=0, count=0; next retire emits seq=0.
REQ-039 SHALL cover saturation and clear: 300 drops -> drop_cnt=0xFF; clr_ovf with concurrent drop -> overflow=0, drop_cnt=0.
